// File: rtl/mem_port_arbiter.sv
// Arbitrates the single block-wide data memory port between icache and dcache.
// The grant is held for the owner's whole miss sequence; the loser is stalled via busywait.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_readdata,
    output logic              i_mem_busywait,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_writedata,
    output logic [DATA_W-1:0] d_mem_readdata,
    output logic              d_mem_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic [1:0]        arb_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   i_req, d_req;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                // Round-robin tie-break favours whichever cache did not own the port last.
                if (i_req && d_req) begin
                    if (FIXED_PRIO || !last_d_q) state_d = OWN_D;
                    else                         state_d = OWN_I;
                end else if (i_req) begin
                    state_d = OWN_I;
                end else if (d_req) begin
                    state_d = OWN_D;
                end
            end
            OWN_I: begin
                if (!i_req) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        i_mem_readdata = '0;
        d_mem_readdata = '0;
        i_mem_busywait = i_req;
        d_mem_busywait = d_req;
        arb_owner      = state_q;
        unique case (state_q)
            OWN_I: begin
                mem_read       = i_mem_read;
                mem_address    = i_mem_address;
                i_mem_readdata = mem_readdata;
                i_mem_busywait = mem_busywait;
            end
            OWN_D: begin
                mem_read       = d_mem_read;
                mem_write      = d_mem_write;
                mem_address    = d_mem_address;
                mem_writedata  = d_mem_writedata;
                d_mem_readdata = mem_readdata;
                d_mem_busywait = mem_busywait;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin instance and a fixed-priority
// instance share the stimulus; expected outputs are queued as each row is driven.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] WDATA = 32'hDEADBEEF;
    localparam logic [DW-1:0] RDATA = 32'hCAFEF00D;

    logic          clock, reset;
    logic          i_mem_read, d_mem_read, d_mem_write, mem_busywait;
    logic [AW-1:0] i_mem_address, d_mem_address;
    logic [DW-1:0] d_mem_writedata, mem_readdata;

    logic [DW-1:0] i_rd_a, d_rd_a, wd_a, i_rd_b, d_rd_b, wd_b;
    logic          i_bw_a, d_bw_a, mr_a, mw_a, i_bw_b, d_bw_b, mr_b, mw_b;
    logic [AW-1:0] ma_a, ma_b;
    logic [1:0]    own_a, own_b;

    int checks   = 0;
    int failures = 0;

    typedef logic [107:0] vec_t;
    vec_t sb[$];

    typedef struct {
        logic          rst, ird, drd, dwr, mbw;
        logic [AW-1:0] ia, da;
        logic [1:0]    own;
        logic          mr, mw;
        logic [AW-1:0] ma;
        logic          ib, db;
    } row_t;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut_rr (
        .clock(clock), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_readdata(i_rd_a), .i_mem_busywait(i_bw_a),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
        .d_mem_readdata(d_rd_a), .d_mem_busywait(d_bw_a),
        .mem_read(mr_a), .mem_write(mw_a), .mem_address(ma_a), .mem_writedata(wd_a),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait), .arb_owner(own_a)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
        .clock(clock), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_readdata(i_rd_b), .i_mem_busywait(i_bw_b),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
        .d_mem_readdata(d_rd_b), .d_mem_busywait(d_bw_b),
        .mem_read(mr_b), .mem_write(mw_b), .mem_address(ma_b), .mem_writedata(wd_b),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait), .arb_owner(own_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t obs_a();
        return {own_a, mr_a, mw_a, ma_a, wd_a, i_bw_a, d_bw_a, i_rd_a, d_rd_a};
    endfunction

    function automatic vec_t obs_b();
        return {own_b, mr_b, mw_b, ma_b, wd_b, i_bw_b, d_bw_b, i_rd_b, d_rd_b};
    endfunction

    function automatic row_t mk(logic rst, logic ird, logic drd, logic dwr, logic mbw,
                                logic [AW-1:0] ia, logic [AW-1:0] da,
                                logic [1:0] own, logic mr, logic mw, logic [AW-1:0] ma,
                                logic ib, logic db);
        row_t r;
        r.rst = rst; r.ird = ird; r.drd = drd; r.dwr = dwr; r.mbw = mbw;
        r.ia = ia; r.da = da; r.own = own; r.mr = mr; r.mw = mw; r.ma = ma;
        r.ib = ib; r.db = db;
        return r;
    endfunction

    // Writedata and readdata expectations follow from the owner named in the row.
    task automatic drive(input row_t r);
        logic [DW-1:0] wd, ird, drd;
        reset         = r.rst;
        i_mem_read    = r.ird;
        d_mem_read    = r.drd;
        d_mem_write   = r.dwr;
        mem_busywait  = r.mbw;
        i_mem_address = r.ia;
        d_mem_address = r.da;
        wd  = (r.own == 2'b10) ? WDATA : '0;
        ird = (r.own == 2'b01) ? RDATA : '0;
        drd = (r.own == 2'b10) ? RDATA : '0;
        sb.push_back({r.own, r.mr, r.mw, r.ma, wd, r.ib, r.db, ird, drd});
    endtask

    task automatic test_reset();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(1,1,0,0,0, 6'h15,6'h00, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(1,0,1,0,1, 6'h15,6'h0A, 2'b00,0,0,6'h00, 0,1));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL test_reset step=%0d got=%h exp=%h", k, obs_a(), e);
            end
        end
    endtask

    task automatic test_icache_alone();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(0,1,0,0,1, 6'h15,6'h00, 2'b01,1,0,6'h15, 1,0));
        rows.push_back(mk(0,1,0,0,0, 6'h15,6'h00, 2'b01,1,0,6'h15, 0,0));
        rows.push_back(mk(0,0,0,0,0, 6'h15,6'h00, 2'b00,0,0,6'h00, 0,0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL test_icache_alone step=%0d got=%h exp=%h", k, obs_a(), e);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(1,0,0,0,0, 6'h03,6'h0A, 2'b00,0,0,6'h00, 0,0));
        rows.push_back(mk(0,1,1,0,1, 6'h03,6'h0A, 2'b01,1,0,6'h03, 1,1));
        rows.push_back(mk(0,0,1,0,1, 6'h03,6'h0A, 2'b00,0,0,6'h00, 0,1));
        rows.push_back(mk(0,0,1,0,1, 6'h03,6'h0A, 2'b10,1,0,6'h0A, 0,1));
        rows.push_back(mk(0,1,0,0,1, 6'h03,6'h0A, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(0,1,1,0,1, 6'h03,6'h0A, 2'b01,1,0,6'h03, 1,1));
        rows.push_back(mk(0,0,1,0,1, 6'h03,6'h0A, 2'b00,0,0,6'h00, 0,1));
        rows.push_back(mk(0,1,1,0,1, 6'h03,6'h0A, 2'b10,1,0,6'h0A, 1,1));
        rows.push_back(mk(0,0,0,0,0, 6'h03,6'h0A, 2'b00,0,0,6'h00, 0,0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL test_round_robin step=%0d got=%h exp=%h", k, obs_a(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(0,0,0,1,1, 6'h15,6'h2A, 2'b10,0,1,6'h2A, 0,1));
        rows.push_back(mk(0,1,0,1,1, 6'h15,6'h2A, 2'b10,0,1,6'h2A, 1,1));
        rows.push_back(mk(0,1,0,1,0, 6'h15,6'h2A, 2'b10,0,1,6'h2A, 1,0));
        rows.push_back(mk(0,1,1,0,1, 6'h15,6'h0A, 2'b10,1,0,6'h0A, 1,1));
        rows.push_back(mk(0,1,1,0,0, 6'h15,6'h0A, 2'b10,1,0,6'h0A, 1,0));
        rows.push_back(mk(0,1,0,0,0, 6'h15,6'h0A, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(0,1,0,0,0, 6'h15,6'h0A, 2'b01,1,0,6'h15, 0,0));
        rows.push_back(mk(0,0,0,0,0, 6'h15,6'h0A, 2'b00,0,0,6'h00, 0,0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL test_back_to_back step=%0d got=%h exp=%h", k, obs_a(), e);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(0,0,1,0,1, 6'h00,6'h0A, 2'b10,1,0,6'h0A, 0,1));
        rows.push_back(mk(1,0,1,0,1, 6'h00,6'h0A, 2'b00,0,0,6'h00, 0,1));
        rows.push_back(mk(0,0,0,0,0, 6'h00,6'h0A, 2'b00,0,0,6'h00, 0,0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_a() !== e) begin
                failures++;
                $display("FAIL test_reset_mid_transfer step=%0d got=%h exp=%h", k, obs_a(), e);
            end
        end
    endtask

    task automatic test_fixed_prio();
        row_t rows[$];
        vec_t e;
        rows.push_back(mk(1,0,0,0,0, 6'h15,6'h0A, 2'b00,0,0,6'h00, 0,0));
        rows.push_back(mk(0,1,1,0,1, 6'h15,6'h0A, 2'b10,1,0,6'h0A, 1,1));
        rows.push_back(mk(0,1,0,0,1, 6'h15,6'h0A, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(0,1,1,0,1, 6'h15,6'h0A, 2'b10,1,0,6'h0A, 1,1));
        rows.push_back(mk(0,1,0,0,1, 6'h15,6'h0A, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(0,1,1,0,0, 6'h15,6'h0A, 2'b10,1,0,6'h0A, 1,0));
        rows.push_back(mk(0,1,0,0,1, 6'h15,6'h0A, 2'b00,0,0,6'h00, 1,0));
        rows.push_back(mk(0,1,0,0,1, 6'h15,6'h0A, 2'b01,1,0,6'h15, 1,0));
        rows.push_back(mk(0,1,1,0,0, 6'h15,6'h0A, 2'b01,1,0,6'h15, 0,1));
        rows.push_back(mk(0,0,0,0,0, 6'h15,6'h0A, 2'b00,0,0,6'h00, 0,0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (obs_b() !== e) begin
                failures++;
                $display("FAIL test_fixed_prio step=%0d got=%h exp=%h", k, obs_b(), e);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        i_mem_read      = 1'b0;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        mem_busywait    = 1'b0;
        i_mem_address   = '0;
        d_mem_address   = '0;
        d_mem_writedata = WDATA;
        mem_readdata    = RDATA;

        test_reset();
        test_icache_alone();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_transfer();
        test_fixed_prio();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
